tube_io_responder: RTL and testbench
====================================

TUBE_IO_RESPONDER -- requirements
Module: tube_io_responder

Interface
REQ-001 Parameter SCAN_DIVISOR, default 100000, system clocks per digit slot (about 1 kHz at 100 MHz); legal range 4 to 2^20.
REQ-002 Parameter BLANK_CYCLES, default 1000, clocks per slot with all digits off (anti-ghosting); SHALL be less than SCAN_DIVISOR.
REQ-003 iClock  input  1  sole clock, rising edge.
REQ-004 iResetN  input  1  asynchronous, active-low reset.
REQ-005 iDoTubeWrite  input  1  one-cycle MMIO write strobe from the CPU controller's tube-write decode.
REQ-006 iDoTubeRead  input  1  one-cycle MMIO read strobe.
REQ-007 iAddressLow  input  4  address[3:0]; 0x0 is the DATA register, 0x4 is the CTRL register, all others reserved.
REQ-008 iWriteData  input  32  store data.
REQ-009 oReadData  output  32  load data, registered.
REQ-010 oSegment  output  8  active-low segments, {dp,g,f,e,d,c,b,a}.
REQ-011 oDigitSelect  output  8  active-low digit enables; bit n drives digit n, digit 0 is rightmost.

Function
REQ-012 DATA SHALL hold eight hex nibbles; nibble n (DATA[4n+3:4n]) is shown on digit n.
REQ-013 CTRL[7:0] SHALL be the digit enable mask, where a 0 bit keeps that digit dark for its slot.
REQ-014 CTRL[15:8] SHALL be the decimal-point mask, where a 1 bit lights dp (oSegment[7]=0) on that digit.
REQ-015 CTRL[31:16] SHALL read back as 0, and writes to it are ignored.
REQ-016 A write with iDoTubeWrite=1 SHALL update the addressed register at that clock edge, and the new value SHALL affect the outputs from the next clock.
REQ-017 Writes to reserved offsets SHALL be ignored.
REQ-018 On a read with iDoTubeRead=1, oReadData SHALL present the addressed register on the next cycle (latency 1).
REQ-019 Reserved offsets SHALL read 0.
REQ-020 oReadData SHALL hold its value until the next read.
REQ-021 If a read and a write hit the same register in the same cycle, the read SHALL return the old value.
REQ-022 A prescale counter SHALL count 0 to SCAN_DIVISOR-1 and wrap; each wrap advances the digit index 7 to 0 to 1 ... to 7 and back to 0.
REQ-023 The scan FSM SHALL have two states, BLANK and SHOW.
REQ-024 The FSM SHALL enter BLANK at each slot start, when the prescale count is 0.
REQ-025 The FSM SHALL move to SHOW when the prescale count reaches BLANK_CYCLES.
REQ-026 The FSM SHALL stay in SHOW until the prescale wraps.
REQ-027 In BLANK, oDigitSelect SHALL be 8'hFF and oSegment SHALL be 8'hFF.
REQ-028 In SHOW, oDigitSelect SHALL have only bit[index] low when the CTRL enable bit for that index is 1; otherwise it SHALL be 8'hFF.
REQ-029 Hex-to-segment decode SHALL give 0->C0, 1->F9, 2->A4, 3->B0, 4->99, 5->92, 6->82, 7->F8, 8->80, 9->90, A->88, b->83, C->C6, d->A1, E->86, F->8E, with bit7 then cleared if dp is set.
REQ-030 oSegment and oDigitSelect SHALL be registered, with no combinational path from inputs to pins.
REQ-031 A write during SHOW SHALL be visible from the next cycle without restarting the scan.

Reset
REQ-032 On iResetN=0, DATA SHALL be 0.
REQ-033 On iResetN=0, CTRL SHALL be 32'h0000_00FF (all digits on, no dp).
REQ-034 On iResetN=0, the prescale count SHALL be 0, the index 0, and the FSM in BLANK.
REQ-035 On iResetN=0, oReadData SHALL be 0, oSegment 8'hFF and oDigitSelect 8'hFF.
REQ-036 Reset assertion mid-slot SHALL force all outputs dark immediately (asynchronously).
REQ-037 After reset release, scanning SHALL resume from digit 0 in BLANK.

Structure
REQ-038 The register offsets (DATA 0x0, CTRL 0x4), the CTRL reset value and the FSM state encodings SHALL live in the shared io_pkg package.
REQ-039 Hex-to-segment decode SHALL be a separate combinational sub-module, seg7_decoder (4-bit in, 7-bit out).

Verification
REQ-040 Timing parameters: run with SCAN_DIVISOR=8 and BLANK_CYCLES=2.
REQ-041 Reset and scan: after reset release, oDigitSelect SHALL step FF,FF,FE (6 cycles),FF,FF,FD ... through 7F, then return to FE.
REQ-042 Write DATA: write 0x0 = 32'h8765_43A1, then digit 0 SHALL show 8'hF9, digit 1 8'h88 and digit 7 8'h80.
REQ-043 Masking: write 0x4 = 32'h0000_02FE, then digit 0 slot SHALL keep oDigitSelect at FF, and digit 1 SHALL show its segment code with bit7 = 0.
REQ-044 Readback: read 0x4 after that write SHALL give oReadData = 32'h0000_02FE one cycle later; read 0xC SHALL give 0; a same-cycle read and write of 0x0 SHALL return the prior DATA.
REQ-045 Async reset: assert iResetN low during a SHOW cycle, then oSegment and oDigitSelect SHALL be FF before the next clock edge, DATA SHALL read 0 and CTRL SHALL read 32'h0000_00FF.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the tube display responder: register map, CTRL reset value, scan FSM states.
`default_nettype none

package io_pkg;

  localparam logic [3:0]  DATA_OFFSET = 4'h0;
  localparam logic [3:0]  CTRL_OFFSET = 4'h4;
  localparam logic [31:0] CTRL_RESET  = 32'h0000_00FF;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/tube_io_responder_if.sv
// MMIO strobe/data bus plus display pins between the CPU side and the tube responder.
`default_nettype none

interface tube_io_responder_if;

  logic        iDoTubeWrite;
  logic        iDoTubeRead;
  logic [3:0]  iAddressLow;
  logic [31:0] iWriteData;
  logic [31:0] oReadData;
  logic [7:0]  oSegment;
  logic [7:0]  oDigitSelect;

  modport master (
    output iDoTubeWrite,
    output iDoTubeRead,
    output iAddressLow,
    output iWriteData,
    input  oReadData,
    input  oSegment,
    input  oDigitSelect
  );

  modport slave (
    input  iDoTubeWrite,
    input  iDoTubeRead,
    input  iAddressLow,
    input  iWriteData,
    output oReadData,
    output oSegment,
    output oDigitSelect
  );

endinterface

`default_nettype wire

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low seven-segment pattern, output ordered {g,f,e,d,c,b,a}.
`default_nettype none

module seg7_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/tube_io_responder.sv
// Memory-mapped eight-digit seven-segment scanner with per-slot blanking and DATA/CTRL registers.
`default_nettype none

module tube_io_responder
  import io_pkg::*;
#(
  parameter int SCAN_DIVISOR = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                 iClock,
  input  logic                 iResetN,
  tube_io_responder_if.slave   bus
);

  localparam int              CNT_W    = (SCAN_DIVISOR > 2) ? $clog2(SCAN_DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);

  logic [31:0]      data_reg;
  logic [15:0]      ctrl_reg;
  logic [31:0]      read_data;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [2:0]       index;
  logic [2:0]       index_next;
  scan_state_t      state;
  scan_state_t      state_next;

  logic [7:0]       segment;
  logic [7:0]       digit_sel;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic             lit;

  // Only CTRL[15:0] is storage; the upper half is hard-wired to zero.
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      data_reg <= '0;
      ctrl_reg <= CTRL_RESET[15:0];
    end else if (bus.iDoTubeWrite) begin
      if (bus.iAddressLow == DATA_OFFSET) begin
        data_reg <= bus.iWriteData;
      end else if (bus.iAddressLow == CTRL_OFFSET) begin
        ctrl_reg <= bus.iWriteData[15:0];
      end
    end
  end

  // Nonblocking update means a same-cycle write is not seen by the read.
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      read_data <= '0;
    end else if (bus.iDoTubeRead) begin
      if (bus.iAddressLow == DATA_OFFSET) begin
        read_data <= data_reg;
      end else if (bus.iAddressLow == CTRL_OFFSET) begin
        read_data <= {16'h0000, ctrl_reg};
      end else begin
        read_data <= '0;
      end
    end
  end

  always_comb begin
    count_next = (count == CNT_LAST) ? '0 : count + 1'b1;
    index_next = (count == CNT_LAST) ? index + 3'd1 : index;
    state_next = state;
    if (count_next == '0) begin
      state_next = ST_BLANK;
    end
    if (count_next == CNT_SHOW) begin
      state_next = ST_SHOW;
    end
    nibble = data_reg[{index_next, 2'b00} +: 4];
    lit    = (state_next == ST_SHOW) && ctrl_reg[index_next];
  end

  seg7_decoder u_decoder (
    .hex (nibble),
    .seg (glyph)
  );

  // Pins are computed from next-state values so they line up with the state register.
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      count     <= '0;
      index     <= 3'd0;
      state     <= ST_BLANK;
      segment   <= 8'hFF;
      digit_sel <= 8'hFF;
    end else begin
      count <= count_next;
      index <= index_next;
      state <= state_next;
      if (lit) begin
        digit_sel <= ~(8'h01 << index_next);
        segment   <= {~ctrl_reg[{1'b1, index_next}], glyph};
      end else begin
        digit_sel <= 8'hFF;
        segment   <= 8'hFF;
      end
    end
  end

  assign bus.oReadData    = read_data;
  assign bus.oSegment     = segment;
  assign bus.oDigitSelect = digit_sel;

endmodule

`default_nettype wire

// File: tb/tb_tube_io_responder.sv
// Directed bench: continuous scan model, table of register accesses, hand-written display and reset sequences.
`default_nettype none

module tb_tube_io_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tube_io_responder_if bus ();

  tube_io_responder #(
    .SCAN_DIVISOR (8),
    .BLANK_CYCLES (2)
  ) dut (
    .iClock  (clk),
    .iResetN (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic [31:0] sd     = 32'h0;
  logic [15:0] sc     = 16'h00FF;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_lut(input logic [3:0] h);
    case (h)
      4'h0: seg_lut = 8'hC0;  4'h1: seg_lut = 8'hF9;
      4'h2: seg_lut = 8'hA4;  4'h3: seg_lut = 8'hB0;
      4'h4: seg_lut = 8'h99;  4'h5: seg_lut = 8'h92;
      4'h6: seg_lut = 8'h82;  4'h7: seg_lut = 8'hF8;
      4'h8: seg_lut = 8'h80;  4'h9: seg_lut = 8'h90;
      4'hA: seg_lut = 8'h88;  4'hB: seg_lut = 8'h83;
      4'hC: seg_lut = 8'hC6;  4'hD: seg_lut = 8'hA1;
      4'hE: seg_lut = 8'h86;  default: seg_lut = 8'h8E;
    endcase
  endfunction

  // Expected pins after each rising edge come from the slot position since reset release.
  task automatic monitor();
    logic [2:0] cnt;
    logic [2:0] idx;
    logic       show;
    logic [7:0] es;
    logic [7:0] eg;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        cyc = 0;
        sd  = 32'h0;
        sc  = 16'h00FF;
        es  = 8'hFF;
        eg  = 8'hFF;
      end else begin
        cyc++;
        cnt  = 3'(cyc % 8);
        idx  = 3'((cyc / 8) % 8);
        show = (cnt >= 3'd2) && sc[idx];
        es   = show ? ~(8'h01 << idx) : 8'hFF;
        eg   = show ? (seg_lut(sd[idx*4 +: 4]) & (sc[8+idx] ? 8'h7F : 8'hFF)) : 8'hFF;
        if (bus.iDoTubeWrite) begin
          if (bus.iAddressLow == 4'h0) sd = bus.iWriteData;
          else if (bus.iAddressLow == 4'h4) sc = bus.iWriteData[15:0];
        end
      end
      #1;
      check("scan_digit_sel", {24'h0, bus.oDigitSelect}, {24'h0, es});
      check("scan_segment",   {24'h0, bus.oSegment},     {24'h0, eg});
    end
  endtask

  task automatic do_access(input logic wr, input logic rd, input logic [3:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.iDoTubeWrite = wr;
    bus.iDoTubeRead  = rd;
    bus.iAddressLow  = addr;
    bus.iWriteData   = wdata;
    @(negedge clk);
    bus.iDoTubeWrite = 1'b0;
    bus.iDoTubeRead  = 1'b0;
    bus.iAddressLow  = 4'h0;
    bus.iWriteData   = 32'h0;
  endtask

  task automatic wait_digit(input logic [7:0] tgt, input string name);
    bit found = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.oDigitSelect == tgt) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: digit select never reached %h, last %h", name, tgt, bus.oDigitSelect);
    end
  endtask

  initial begin
    int fe_seen;
    bus.iDoTubeWrite = 1'b0;
    bus.iDoTubeRead  = 1'b0;
    bus.iAddressLow  = 4'h0;
    bus.iWriteData   = 32'h0;

    vecs[0]  = '{1'b0, 1'b1, 4'h4, 32'h0,          32'h0000_00FF};
    vecs[1]  = '{1'b0, 1'b1, 4'h0, 32'h0,          32'h0000_0000};
    vecs[2]  = '{1'b1, 1'b0, 4'h0, 32'h8765_43A1,  32'h0000_0000};
    vecs[3]  = '{1'b0, 1'b1, 4'h0, 32'h0,          32'h8765_43A1};
    vecs[4]  = '{1'b1, 1'b0, 4'h4, 32'hFFFF_02FE,  32'h8765_43A1};
    vecs[5]  = '{1'b0, 1'b1, 4'h4, 32'h0,          32'h0000_02FE};
    vecs[6]  = '{1'b0, 1'b1, 4'hC, 32'h0,          32'h0000_0000};
    vecs[7]  = '{1'b1, 1'b0, 4'h8, 32'hDEAD_BEEF,  32'h0000_0000};
    vecs[8]  = '{1'b0, 1'b1, 4'h8, 32'h0,          32'h0000_0000};
    vecs[9]  = '{1'b0, 1'b1, 4'h0, 32'h0,          32'h8765_43A1};
    vecs[10] = '{1'b0, 1'b1, 4'h4, 32'h0,          32'h0000_02FE};
    vecs[11] = '{1'b1, 1'b1, 4'h0, 32'h1234_5678,  32'h8765_43A1};
    vecs[12] = '{1'b0, 1'b1, 4'h0, 32'h0,          32'h1234_5678};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 32'h8765_43A1,  32'h1234_5678};

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("reset_digit_sel", {24'h0, bus.oDigitSelect}, 32'h0000_00FF);
    check("reset_segment",   {24'h0, bus.oSegment},     32'h0000_00FF);
    check("reset_read_data", bus.oReadData,             32'h0);
    rst_n = 1'b1;

    // One full frame plus the wrap back to digit 0.
    repeat (66) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      do_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_read_data", i), bus.oReadData, vecs[i].exp);
    end

    do_access(1'b1, 1'b0, 4'h4, 32'h0000_00FF);
    wait_digit(8'hFE, "wait_digit0");
    check("digit0_segment", {24'h0, bus.oSegment}, 32'h0000_00F9);
    wait_digit(8'hFD, "wait_digit1");
    check("digit1_segment", {24'h0, bus.oSegment}, 32'h0000_0088);
    wait_digit(8'h7F, "wait_digit7");
    check("digit7_segment", {24'h0, bus.oSegment}, 32'h0000_0080);

    do_access(1'b1, 1'b0, 4'h4, 32'h0000_02FE);
    wait_digit(8'hFD, "wait_digit1_dp");
    check("digit1_dp_segment", {24'h0, bus.oSegment}, 32'h0000_0008);
    fe_seen = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (bus.oDigitSelect == 8'hFE) fe_seen++;
    end
    check("digit0_masked_count", fe_seen, 32'd0);

    // Asynchronous reset in the middle of a lit slot.
    wait_digit(8'hFD, "wait_show_for_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_digit_sel", {24'h0, bus.oDigitSelect}, 32'h0000_00FF);
    check("async_segment",   {24'h0, bus.oSegment},     32'h0000_00FF);
    check("async_read_data", bus.oReadData,             32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_access(1'b0, 1'b1, 4'h0, 32'h0);
    check("post_reset_data", bus.oReadData, 32'h0);
    do_access(1'b0, 1'b1, 4'h4, 32'h0);
    check("post_reset_ctrl", bus.oReadData, 32'h0000_00FF);
    repeat (70) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
